// File: rtl/playback_sequencer_if.sv
// playback_sequencer_if: FIFO-to-DAC playback bus; underrun_count is present only with UNDERRUN_CNT_EN.
// master = sequencer side, slave = FIFO/DAC/UART side.
interface playback_sequencer_if #(
   parameter int BITS      = 16,
   parameter int FILL_BITS = 13
);
   logic                 play_en;
   logic [FILL_BITS-1:0] fifo_fill;
   logic                 fifo_empty;
   logic [BITS-1:0]      fifo_rd_data;
   logic                 fifo_rd_en;
   logic [BITS-1:0]      sample_out;
   logic                 sample_strobe;
   logic                 dac_reset;
   logic                 rx_ready;
   logic [1:0]           state_o;
`ifdef UNDERRUN_CNT_EN
   logic [7:0]           underrun_count;
`endif
   modport master (
      input  play_en, fifo_fill, fifo_empty, fifo_rd_data,
      output fifo_rd_en, sample_out, sample_strobe, dac_reset, rx_ready, state_o
`ifdef UNDERRUN_CNT_EN
      , output underrun_count
`endif
   );
   modport slave (
      output play_en, fifo_fill, fifo_empty, fifo_rd_data,
      input  fifo_rd_en, sample_out, sample_strobe, dac_reset, rx_ready, state_o
`ifdef UNDERRUN_CNT_EN
      , input underrun_count
`endif
   );
endinterface

// File: rtl/playback_sequencer.sv
// playback_sequencer: paces FIFO reads into the DAC with prefill, underrun detection and hysteretic flow control.
// Define UNDERRUN_CNT_EN to add the saturating underrun_count output.
module playback_sequencer #(
   parameter int MAIN_CLOCK_FREQ = 12_000_000,
   parameter int SAMPLE_FREQ     = 11_025,
   parameter int BITS            = 16,
   parameter int FIFO_SIZE       = 8192,
   parameter int START_LEVEL     = 4096,
   parameter int LOW_LEVEL       = 819,
   parameter int HIGH_LEVEL      = 7373
) (
   input logic                  CLK_IN,
   input logic                  reset,
   playback_sequencer_if.master bus
);
   localparam int DAC_COUNTER = MAIN_CLOCK_FREQ / SAMPLE_FREQ;
   localparam int FILL_BITS   = $clog2(FIFO_SIZE);
   localparam int DIV_BITS    = $clog2(DAC_COUNTER);
   localparam logic [DIV_BITS-1:0]  DIV_LOAD = DIV_BITS'(DAC_COUNTER - 1);
   localparam logic [FILL_BITS-1:0] START_L  = FILL_BITS'(START_LEVEL);
   localparam logic [FILL_BITS-1:0] LOW_L    = FILL_BITS'(LOW_LEVEL);
   localparam logic [FILL_BITS-1:0] HIGH_L   = FILL_BITS'(HIGH_LEVEL);

   typedef enum logic [1:0] {IDLE = 2'd0, PREFILL = 2'd1, PLAY = 2'd2} state_t;

   state_t              r_state, w_next;
   logic [DIV_BITS-1:0] r_div;
   logic                w_tick, w_rd, w_underrun;
   logic                r_pend, r_strobe, r_dac_rst, r_rx;
   logic [BITS-1:0]     r_sample;

   assign w_tick = r_div == '0;

   always_comb begin
      w_next     = r_state;
      w_rd       = 1'b0;
      w_underrun = 1'b0;
      case (r_state)
         IDLE:    w_next = bus.play_en ? PREFILL : IDLE;
         PREFILL: w_next = !bus.play_en ? IDLE : (bus.fifo_fill >= START_L) ? PLAY : PREFILL;
         PLAY: begin
            w_next     = !w_tick ? PLAY : !bus.play_en ? IDLE : bus.fifo_empty ? PREFILL : PLAY;
            w_rd       = w_tick && bus.play_en && !bus.fifo_empty;
            w_underrun = w_tick && bus.play_en && bus.fifo_empty;
         end
         default: w_next = IDLE;
      endcase
   end

   // Read data arrives the cycle after the strobe, so the capture is one cycle pending.
   always_ff @(posedge CLK_IN) begin
      if (reset) begin
         r_div     <= DIV_LOAD;
         r_state   <= IDLE;
         r_pend    <= 1'b0;
         r_strobe  <= 1'b0;
         r_sample  <= '0;
         r_dac_rst <= 1'b1;
         r_rx      <= 1'b1;
      end else begin
         r_div     <= w_tick ? DIV_LOAD : r_div - 1'b1;
         r_state   <= w_next;
         r_pend    <= w_rd;
         r_strobe  <= r_pend;
         r_sample  <= r_pend ? bus.fifo_rd_data : r_sample;
         r_dac_rst <= r_state != PLAY;
         r_rx      <= (bus.fifo_fill >= HIGH_L) ? 1'b0 : (bus.fifo_fill <= LOW_L) ? 1'b1 : r_rx;
      end
   end

`ifdef UNDERRUN_CNT_EN
   logic [7:0] r_ur_cnt;
   always_ff @(posedge CLK_IN) begin
      if (reset) r_ur_cnt <= '0;
      else if (w_underrun && r_ur_cnt != 8'hff) r_ur_cnt <= r_ur_cnt + 1'b1;
   end
   assign bus.underrun_count = r_ur_cnt;
`else
   logic w_unused_ur;
   assign w_unused_ur = w_underrun;
`endif

   assign bus.fifo_rd_en    = w_rd;
   assign bus.sample_out    = r_sample;
   assign bus.sample_strobe = r_strobe;
   assign bus.dac_reset     = r_dac_rst;
   assign bus.rx_ready      = r_rx;
   assign bus.state_o       = r_state;
endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer: directed checks of prefill, playback pacing, underrun, stop, flow control and reset.
module tb_playback_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [3:0]  m_div;
   logic [15:0] word = 16'h1234;

   playback_sequencer_if #(.BITS(16), .FILL_BITS(6)) bus ();

   playback_sequencer #(
      .MAIN_CLOCK_FREQ(1000), .SAMPLE_FREQ(100), .BITS(16), .FIFO_SIZE(64),
      .START_LEVEL(32), .LOW_LEVEL(8), .HIGH_LEVEL(56)
   ) dut (
      .CLK_IN(clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Tick reference: 10-cycle divider, tick while it reads 0.
   always @(posedge clk) m_div <= (reset || m_div == 4'd0) ? 4'd9 : m_div - 4'd1;

   // FIFO with one cycle of read latency.
   always @(posedge clk) if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= word;
      word <= word + 16'd1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic wait_div(input logic [3:0] v);
      int k = 0;
      do begin
         cyc();
         k++;
      end while (m_div != v && k < 20);
   endtask

   initial begin
      int n;
      logic got;
      bus.play_en = 1'b0;
      bus.fifo_fill = 6'd0;
      bus.fifo_empty = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      smp();
      chk("rst_state", 32'(bus.state_o), 0);
      chk("rst_dacr", 32'(bus.dac_reset), 1);
      chk("rst_rx", 32'(bus.rx_ready), 1);
      chk("rst_sample", 32'(bus.sample_out), 0);
      chk("rst_strobe", 32'(bus.sample_strobe), 0);
      n = 0;
      repeat (100) begin
         cyc();
         smp();
         if (bus.fifo_rd_en) n++;
      end
      chk("idle_no_rd", 32'(n), 0);

      // Prefill below START_LEVEL never leaves PREFILL.
      n = 0;
      for (int f = 0; f < 32; f++) begin
         cyc();
         bus.play_en = 1'b1;
         bus.fifo_fill = 6'(f);
         bus.fifo_empty = (f == 0);
         smp();
         if (f > 0 && bus.state_o != 2'd1) n++;
      end
      chk("prefill_hold", 32'(n), 0);
      wait_div(4'd5);
      bus.fifo_fill = 6'd32;
      smp();
      chk("prefill_last", 32'(bus.state_o), 1);
      cyc(); smp();
      chk("play_entry", 32'(bus.state_o), 2);
      chk("dacr_entry", 32'(bus.dac_reset), 1);
      chk("no_rd_entry", 32'(bus.fifo_rd_en), 0);
      cyc(); smp();
      chk("dacr_fall", 32'(bus.dac_reset), 0);
      n = 0;
      repeat (2) begin
         cyc(); smp();
         if (bus.fifo_rd_en) n++;
      end
      chk("no_rd_early", 32'(n), 0);
      cyc(); smp();
      chk("rd_first", 32'(bus.fifo_rd_en), 1);
      cyc(); smp();
      chk("rd_one_cycle", 32'(bus.fifo_rd_en), 0);
      chk("strobe_wait", 32'(bus.sample_strobe), 0);
      cyc(); smp();
      chk("strobe1", 32'(bus.sample_strobe), 1);
      chk("sample1", 32'(bus.sample_out), 32'h1234);
      cyc(); smp();
      chk("strobe1_end", 32'(bus.sample_strobe), 0);
      repeat (6) cyc();
      smp();
      chk("rd_gap", 32'(bus.fifo_rd_en), 0);
      cyc(); smp();
      chk("rd_second", 32'(bus.fifo_rd_en), 1);
      cyc(); cyc(); smp();
      chk("sample2", 32'(bus.sample_out), 32'h1235);

      // Underrun at the next tick with the FIFO empty.
      wait_div(4'd3);
      bus.fifo_empty = 1'b1;
      bus.fifo_fill = 6'd0;
      repeat (3) cyc();
      smp();
      chk("ur_no_rd", 32'(bus.fifo_rd_en), 0);
      chk("ur_tick_state", 32'(bus.state_o), 2);
      cyc(); smp();
      chk("ur_state", 32'(bus.state_o), 1);
      cyc(); smp();
      chk("ur_dacr", 32'(bus.dac_reset), 1);
      chk("ur_hold", 32'(bus.sample_out), 32'h1235);
`ifdef UNDERRUN_CNT_EN
      chk("ur_count1", 32'(bus.underrun_count), 1);
`endif
      bus.fifo_fill = 6'd32;
      repeat (3010) cyc();
      smp();
      chk("ur_loop_state", 32'(bus.state_o != 2'd0), 1);
`ifdef UNDERRUN_CNT_EN
      chk("ur_count_sat", 32'(bus.underrun_count), 255);
`endif

      // Stop mid-period takes effect at the next tick, without a read.
      bus.fifo_empty = 1'b0;
      wait_div(4'd5);
      bus.play_en = 1'b0;
      smp();
      chk("stop_pre", 32'(bus.state_o), 2);
      repeat (4) cyc();
      smp();
      chk("stop_wait", 32'(bus.state_o), 2);
      cyc(); smp();
      chk("stop_no_rd", 32'(bus.fifo_rd_en), 0);
      chk("stop_tick_state", 32'(bus.state_o), 2);
      cyc(); smp();
      chk("stop_idle", 32'(bus.state_o), 0);
      cyc(); smp();
      chk("stop_dacr", 32'(bus.dac_reset), 1);
`ifdef UNDERRUN_CNT_EN
      chk("stop_count", 32'(bus.underrun_count), 255);
`endif

      // Flow-control hysteresis.
      cyc();
      bus.fifo_fill = 6'd0;
      n = 0;
      for (int f = 1; f <= 56; f++) begin
         cyc();
         bus.fifo_fill = 6'(f);
         smp();
         if (bus.rx_ready !== 1'b1) n++;
      end
      chk("rx_ramp_up", 32'(n), 0);
      cyc(); smp();
      chk("rx_fall", 32'(bus.rx_ready), 0);
      n = 0;
      for (int f = 55; f >= 9; f--) begin
         cyc();
         bus.fifo_fill = 6'(f);
         smp();
         if (bus.rx_ready !== 1'b0) n++;
      end
      chk("rx_ramp_down", 32'(n), 0);
      cyc();
      bus.fifo_fill = 6'd8;
      smp();
      chk("rx_at9", 32'(bus.rx_ready), 0);
      cyc(); smp();
      chk("rx_rise", 32'(bus.rx_ready), 1);

      // Reset in the cycle after a read discards the pending capture.
      bus.play_en = 1'b1;
      bus.fifo_fill = 6'd32;
      bus.fifo_empty = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         cyc(); smp();
         got = bus.fifo_rd_en;
      end
      chk("rst_rd_seen", 32'(got), 1);
      chk("rst_pre_sample", 32'(bus.sample_out != 16'd0), 1);
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      bus.play_en = 1'b0;
      smp();
      chk("rst_mid_strobe", 32'(bus.sample_strobe), 0);
      chk("rst_mid_sample", 32'(bus.sample_out), 0);
      chk("rst_mid_state", 32'(bus.state_o), 0);
      chk("rst_mid_dacr", 32'(bus.dac_reset), 1);
      cyc(); smp();
      chk("rst_mid_strobe2", 32'(bus.sample_strobe), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
